ltc2311_sample_averager: RTL

- Downstream consumer of the LTC2311 capture path. Drains the 16-bit sample FIFO through its empty flag, read-enable and read-data interface.
- Accumulates 2^k signed samples, then emits one rounded, saturated average over a valid/ready handshake to the next stage (DMA/stream packer).
- Provides hardware decimation and noise reduction, so software does not poll the FIFO per sample.

---
 rtl/ltc2311_pkg.sv | 30 +++
 rtl/ltc2311_sample_averager_round_sat.sv | 32 +++
 rtl/ltc2311_sample_averager.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ltc2311_pkg.sv
// Shared types and helpers for the LTC2311 sample averaging path.
package ltc2311_pkg;

  localparam int ADC_DATA_WIDTH     = 16;
  localparam int MAX_LOG2_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_ACC,
    S_OUT
  } avg_state_t;

  // Clamp a signed value into the two's-complement range of 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int                 width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/ltc2311_sample_averager_round_sat.sv
// Divides a block sum by 2^k with round-half-up, then saturates to the sample width.
module avg_round_sat
  import ltc2311_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int MAX_LOG2_N = MAX_LOG2_N_DEFAULT,
  parameter int K_W        = 4
) (
  input  logic signed [DATA_WIDTH+MAX_LOG2_N-1:0] i_sum,
  input  logic        [K_W-1:0]                   i_k,
  output logic        [DATA_WIDTH-1:0]            o_avg_data
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2_N;
  localparam int EXT_W = ACC_W + 1;

  logic signed [EXT_W-1:0] w_sum_ext;
  logic signed [EXT_W-1:0] w_bias;
  logic signed [EXT_W-1:0] w_rounded;
  logic signed [EXT_W-1:0] w_shifted;

  assign w_sum_ext = {i_sum[ACC_W-1], i_sum};

  // Half an LSB of the shifted result; zero for k=0 so the passthrough stays exact.
  assign w_bias = (i_k == '0) ? '0
                : ({{(EXT_W-1){1'b0}}, 1'b1} << (i_k - K_W'(1)));

  assign w_rounded  = w_sum_ext + w_bias;
  assign w_shifted  = w_rounded >>> i_k;
  assign o_avg_data = DATA_WIDTH'(sat_signed(64'(w_shifted), DATA_WIDTH));

endmodule

// File: rtl/ltc2311_sample_averager.sv
// Drains the LTC2311 sample FIFO, averages blocks of 2^k signed samples and
// hands each rounded result downstream over a valid/ready handshake.
module ltc2311_sample_averager
  import ltc2311_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int MAX_LOG2_N = MAX_LOG2_N_DEFAULT,
  parameter int K_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [K_W-1:0]        avg_log2,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_enable,
  output logic [DATA_WIDTH-1:0] avg_data,
  output logic                  avg_valid,
  input  logic                  avg_ready,
  output logic                  busy,
  output logic [15:0]           result_count
);

  localparam int              ACC_W = DATA_WIDTH + MAX_LOG2_N;
  localparam int              CNT_W = MAX_LOG2_N + 1;
  localparam logic [K_W-1:0]  K_MAX = K_W'(MAX_LOG2_N);

  avg_state_t               r_state;
  avg_state_t               w_state_next;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W-1:0]  w_sample_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic [CNT_W-1:0]         r_count;
  logic [CNT_W-1:0]         w_count_next;
  logic [CNT_W-1:0]         w_target;
  logic [K_W-1:0]           r_k_latched;
  logic [K_W-1:0]           w_k_next;
  logic [K_W-1:0]           w_k_eff;
  logic                     r_avg_valid;
  logic                     w_avg_valid_next;
  logic [DATA_WIDTH-1:0]    r_avg_data;
  logic [DATA_WIDTH-1:0]    w_avg_data_next;
  logic [DATA_WIDTH-1:0]    w_avg_rounded;
  logic [15:0]              r_result_count;
  logic [15:0]              w_result_count_next;

  assign w_k_eff      = (avg_log2 > K_MAX) ? K_MAX : avg_log2;
  assign w_sample_ext = {{MAX_LOG2_N{fifo_data[DATA_WIDTH-1]}}, fifo_data};
  assign w_sum        = r_acc + w_sample_ext;
  // Index of the last sample in the block; one count bit of headroom keeps k=MAX exact.
  assign w_target     = (CNT_W'(1) << r_k_latched) - CNT_W'(1);

  avg_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_LOG2_N (MAX_LOG2_N),
    .K_W        (K_W)
  ) u_round_sat (
    .i_sum      (w_sum),
    .i_k        (r_k_latched),
    .o_avg_data (w_avg_rounded)
  );

  always_comb begin
    w_state_next        = r_state;
    w_acc_next          = r_acc;
    w_count_next        = r_count;
    w_k_next            = r_k_latched;
    w_avg_valid_next    = r_avg_valid;
    w_avg_data_next     = r_avg_data;
    w_result_count_next = r_result_count;

    case (r_state)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          w_state_next = S_READ;
          if (r_count == '0) begin
            w_k_next = w_k_eff;
          end
        end else if (!enable && (r_count != '0)) begin
          w_acc_next   = '0;
          w_count_next = '0;
        end
      end

      S_READ: begin
        w_state_next = S_ACC;
      end

      S_ACC: begin
        if (r_count == w_target) begin
          w_avg_data_next  = w_avg_rounded;
          w_avg_valid_next = 1'b1;
          w_acc_next       = '0;
          w_count_next     = '0;
          w_state_next     = S_OUT;
        end else begin
          w_acc_next   = w_sum;
          w_count_next = r_count + CNT_W'(1);
          w_state_next = (enable && !fifo_empty) ? S_READ : S_IDLE;
        end
      end

      S_OUT: begin
        if (r_avg_valid && avg_ready) begin
          w_avg_valid_next    = 1'b0;
          w_result_count_next = r_result_count + 16'd1;
          w_state_next        = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_count        <= '0;
      r_k_latched    <= '0;
      r_avg_valid    <= 1'b0;
      r_avg_data     <= '0;
      r_result_count <= '0;
    end else begin
      r_state        <= w_state_next;
      r_acc          <= w_acc_next;
      r_count        <= w_count_next;
      r_k_latched    <= w_k_next;
      r_avg_valid    <= w_avg_valid_next;
      r_avg_data     <= w_avg_data_next;
      r_result_count <= w_result_count_next;
    end
  end

  assign fifo_read_enable = (r_state == S_READ);
  assign avg_valid        = r_avg_valid;
  assign avg_data         = r_avg_data;
  assign result_count     = r_result_count;
  assign busy             = (r_state != S_IDLE) || (r_count != '0);

endmodule
